// File: rtl/fetch_queue.sv
// fetch_queue: instruction-byte prefetch stage between the memory read port
// and the opcode decoder.
//
// Drives the fetch PC as a combinational memory read address, captures each
// returned byte together with its address into a small circular FIFO, and
// presents the head entry to the decoder over a valid/ready handshake. A
// redirect flushes the FIFO and restarts fetching at a new PC.
//
// Parameters:
//   QUEUE_DEPTH    number of byte entries (power of two, >= 2)
//   RESET_PC       fetch PC loaded on reset
//
// Ports:
//   clk             clock, all state on rising edge
//   rst             synchronous active-high reset
//   mem_addr        memory read address (the fetch PC register)
//   mem_data        memory read data for mem_addr, valid in the same cycle
//   fetch_hold      suppress push and PC increment this cycle
//   redirect_valid  flush the queue and reload the fetch PC
//   redirect_pc     new fetch PC
//   op_valid        head entry available
//   op_ready        decoder accepts the head entry
//   op_data         head byte (zero when empty)
//   op_pc           head byte address (zero when empty)
//   fetched_cnt     bytes delivered to the decoder (stats build only)
//   redirect_cnt    redirects taken, saturating (stats build only)
//
// Build option: define FETCH_STATS_EN to include the delivery/redirect
// counters; otherwise fetched_cnt and redirect_cnt are tied to zero.

module fetch_queue #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    input  logic        fetch_hold,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [7:0]  op_data,
    output logic [15:0] op_pc,
    output logic [15:0] fetched_cnt,
    output logic [7:0]  redirect_cnt
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  data;
    } entry_t;

    entry_t             entries_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [15:0]        fetch_pc;
    entry_t             head_q;

    logic               pop;
    logic               push;
    logic [PTR_W-1:0]   rd_nxt;
    logic [PTR_W-1:0]   wr_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [15:0]        pc_nxt;
    entry_t             head_nxt;
    entry_t             new_entry;

    // Next-state for pointers, occupancy, fetch PC and the registered head view.
    always_comb begin
        pop       = (count != '0) && op_ready;
        push      = !redirect_valid && !fetch_hold &&
                    ((count < CNT_W'(QUEUE_DEPTH)) || pop);
        new_entry = '{pc: fetch_pc, data: mem_data};
        rd_nxt    = rd_ptr;
        wr_nxt    = wr_ptr;
        cnt_nxt   = count;
        pc_nxt    = fetch_pc;
        head_nxt  = '0;

        if (redirect_valid) begin
            rd_nxt  = wr_ptr;
            cnt_nxt = '0;
            pc_nxt  = redirect_pc;
        end else begin
            if (pop) begin
                rd_nxt = PTR_W'(rd_ptr + 1'b1);
            end
            if (push) begin
                wr_nxt = PTR_W'(wr_ptr + 1'b1);
                pc_nxt = 16'(fetch_pc + 16'd1);
            end
            if (push && !pop) begin
                cnt_nxt = CNT_W'(count + 1'b1);
            end else if (pop && !push) begin
                cnt_nxt = CNT_W'(count - 1'b1);
            end
        end

        // The next head is the entry being written now when it lands at the
        // new read pointer (queue was empty, or drained to empty by this pop).
        if (cnt_nxt == '0) begin
            head_nxt = '0;
        end else if (push && (rd_nxt == wr_ptr)) begin
            head_nxt = new_entry;
        end else begin
            head_nxt = entries_q[rd_nxt];
        end
    end

    // Control state and registered decoder-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
            head_q   <= '0;
            op_valid <= 1'b0;
        end else begin
            rd_ptr   <= rd_nxt;
            wr_ptr   <= wr_nxt;
            count    <= cnt_nxt;
            fetch_pc <= pc_nxt;
            head_q   <= head_nxt;
            op_valid <= (cnt_nxt != '0);
        end
    end

    // Entry storage; contents are don't-care until written, empty reads are masked.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            entries_q[wr_ptr] <= new_entry;
        end
    end

    assign mem_addr = fetch_pc;
    assign op_data  = head_q.data;
    assign op_pc    = head_q.pc;

`ifdef FETCH_STATS_EN
    logic [15:0] fetched_q;
    logic [7:0]  redirect_q;

    // Delivery counter wraps; redirect counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q  <= '0;
            redirect_q <= '0;
        end else begin
            if (pop) begin
                fetched_q <= 16'(fetched_q + 16'd1);
            end
            if (redirect_valid && (redirect_q != 8'hFF)) begin
                redirect_q <= 8'(redirect_q + 8'd1);
            end
        end
    end

    assign fetched_cnt  = fetched_q;
    assign redirect_cnt = redirect_q;
`else
    assign fetched_cnt  = 16'h0000;
    assign redirect_cnt = 8'h00;
`endif

endmodule
